// File: rtl/hack_pkg.sv
// Shared Hack CPU definitions: jump-field encoding, PC action codes and default widths.
package hack_pkg;

    localparam int unsigned HACK_ADDR_W      = 15;
    localparam int unsigned HACK_STACK_DEPTH = 8;

    // Jump field {j1,j2,j3}: j1 = less-than, j2 = equal, j3 = greater-than.
    typedef enum logic [2:0] {
        J_NULL = 3'b000,
        J_GT   = 3'b001,
        J_EQ   = 3'b010,
        J_GE   = 3'b011,
        J_LT   = 3'b100,
        J_NE   = 3'b101,
        J_LE   = 3'b110,
        J_MP   = 3'b111
    } jcode_t;

    // What the PC does at the next enabled edge.
    typedef enum logic [1:0] {
        ACT_SEQ  = 2'd0,
        ACT_JUMP = 2'd1,
        ACT_PUSH = 2'd2,
        ACT_POP  = 2'd3
    } pc_act_t;

endpackage

// File: rtl/jmp_cond.sv
// Combinational Hack jump-condition evaluator; shared with trace/disassembly tooling.
module jmp_cond
    import hack_pkg::*;
(
    input  jcode_t jcode,
    input  logic   neg,
    input  logic   zero,
    output logic   cond
);

    always_comb begin
        cond = 1'b0;
        unique case (jcode)
            J_NULL: cond = 1'b0;
            J_GT:   cond = ~neg & ~zero;
            J_EQ:   cond = zero;
            J_GE:   cond = ~neg;
            J_LT:   cond = neg;
            J_NE:   cond = ~zero;
            J_LE:   cond = neg | zero;
            J_MP:   cond = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Hack program counter with jump evaluation and a hardware return-address stack.
module pc_unit
    import hack_pkg::*;
#(
    parameter int unsigned ADDR_W      = HACK_ADDR_W,
    parameter int unsigned STACK_DEPTH = HACK_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              c_instr,
    input  logic [2:0]        j,
    input  logic              neg,
    input  logic              zero,
    input  logic [ADDR_W-1:0] target,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc,
    output logic              taken,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

    logic [SP_W-1:0]   sp;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [ADDR_W-1:0] pc_next;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  top_idx;
    logic              cond_raw;
    logic              cond;
    pc_act_t           act;
    logic              err_set;

    jmp_cond u_jmp_cond (
        .jcode (jcode_t'(j)),
        .neg   (neg),
        .zero  (zero),
        .cond  (cond_raw)
    );

    assign cond        = c_instr & cond_raw;
    assign pc_next     = pc + ADDR_W'(1);
    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    // Push slot is only used when not full, pop slot only when not empty.
    assign push_idx    = IDX_W'(sp);
    assign top_idx     = IDX_W'(sp - SP_W'(1));

    // Priority decision: return beats call, call beats plain jump.
    always_comb begin
        act     = ACT_SEQ;
        err_set = 1'b0;
        if (ret) begin
            if (!stack_empty) begin
                act = ACT_POP;
            end else begin
                err_set = 1'b1;
            end
        end else if (call && cond) begin
            if (!stack_full) begin
                act = ACT_PUSH;
            end else begin
                act     = ACT_JUMP;
                err_set = 1'b1;
            end
        end else if (cond) begin
            act = ACT_JUMP;
        end
    end

    assign taken = en & ~rst & (act != ACT_SEQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            sp        <= '0;
            stack_err <= 1'b0;
        end else if (en) begin
            unique case (act)
                ACT_SEQ:  pc <= pc_next;
                ACT_JUMP: pc <= target;
                ACT_PUSH: begin
                    pc <= target;
                    sp <= sp + SP_W'(1);
                end
                ACT_POP: begin
                    pc <= stack_mem[top_idx];
                    sp <= sp - SP_W'(1);
                end
            endcase
            if (err_set) begin
                stack_err <= 1'b1;
            end
        end
    end

    // Stack contents carry no reset; the pointer alone defines validity.
    always_ff @(posedge clk) begin
        if (!rst && en && act == ACT_PUSH) begin
            stack_mem[push_idx] <= pc_next;
        end
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Hack program counter with integrated jump evaluation and a hardware return-address stack.
- Evaluates the 3-bit jump field against the ALU flags (neg, zero), then loads, increments, holds, calls or returns.
- Generalised in PC width and stack depth.
- Sits between the control decoder and ROM address; replaces the separate jump-control-plus-counter arrangement.

Parameters:
- ADDR_W, 15, PC / ROM address width in bits.
- STACK_DEPTH, 8, number of return-address entries (>= 2, power of two not required).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high, sampled on rising clk.
- en  in  1  advance enable; 0 = stall, all state held.
- c_instr  in  1  current instruction is a C-instruction; jump field valid only when 1.
- j  in  3  jump field {j1,j2,j3}, book encoding.
- neg  in  1  ALU result negative.
- zero  in  1  ALU result zero.
- target  in  ADDR_W  jump/call destination (A register, low bits).
- call  in  1  conditional call: if jump condition holds, push return address and jump.
- ret  in  1  return: pop stack into PC (unconditional, ignores j).
- pc  out  ADDR_W  current program counter (registered).
- taken  out  1  combinational: PC will load non-sequentially at next edge.
- stack_empty  out  1  stack pointer == 0.
- stack_full  out  1  stack pointer == STACK_DEPTH.
- stack_err  out  1  sticky overflow/underflow flag; cleared only by rst.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: pc = 0, stack pointer = 0, stack_err = 0, stack contents don't-care.
  - Hence stack_empty = 1, stack_full = 0.
  - taken = 0 while rst = 1.
- Jump condition cond, evaluated only when c_instr = 1, else 0:
  - 000 never
  - 001 JGT: ~neg & ~zero
  - 010 JEQ: zero
  - 011 JGE: ~neg
  - 100 JLT: neg
  - 101 JNE: ~zero
  - 110 JLE: neg | zero
  - 111 JMP: always
- pc_next is pc + 1, wrapping modulo 2^ADDR_W (all ones -> 0, no flag).
- Per rising edge with rst = 0 and en = 1, first matching rule wins:
  1. ret = 1, stack nonempty: pc <= top entry; pointer decrements; taken = 1.
  2. ret = 1, stack empty: pc <= pc_next; stack_err <= 1; taken = 0.
  3. call = 1 and cond = 1, stack not full: push pc_next; pc <= target; taken = 1.
  4. call = 1 and cond = 1, stack full: pc <= target; push dropped, no entry overwritten; stack_err <= 1; taken = 1.
  5. call = 0 and cond = 1: pc <= target; taken = 1.
  6. Otherwise: pc <= pc_next; taken = 0. This includes call = 1 with cond = 0.
- ret and call together: ret wins, call fully ignored, no push.
- en = 0: pc, pointer, stack and stack_err all hold; taken = 0.
- Latency: decision combinational; new pc visible one cycle after the decision edge.
- rst asserted mid call or return sequence: stack discarded, pointer = 0 at the next edge; no partial push/pop effects.
- stack_empty and stack_full are derived combinationally from the registered pointer; pointer width is $clog2(STACK_DEPTH+1).

Decomposition:
- Shared package hack_pkg:
  - enum jcode_t (J_NULL, J_GT, J_EQ, J_GE, J_LT, J_NE, J_LE, J_MP) with the 3-bit encodings above.
  - Default constant HACK_ADDR_W = 15.
- Sub-module jmp_cond: purely combinational, (jcode_t, neg, zero) -> cond. Also reusable by the disassembler/trace monitor.
- pc_unit holds the PC register, pointer register and stack array.

Test Plan:
- Reset and increment: rst 1 cycle, then en = 1, c_instr = 0 for 5 cycles -> pc = 0,1,2,3,4,5; taken = 0 throughout; stack_empty = 1.
- All 8 jump codes × flag pairs (neg,zero) ∈ {(0,0),(0,1),(1,0)}, target = 0x1234, pc = 0x0010:
  - cond = 1 -> next pc = 0x1234.
  - Otherwise -> next pc = 0x0011; taken matches the table.
- Call/return nesting with STACK_DEPTH = 4:
  - call with j = 111 at pc 0x0005 to 0x0100 -> pc = 0x0100, stack holds 0x0006.
  - Nested call at 0x0102 to 0x0200 -> stack holds 0x0103, 0x0006.
  - Two rets -> pc = 0x0103, then 0x0006; stack_empty = 1; stack_err = 0.
- Overflow/underflow with STACK_DEPTH = 4:
  - 5 taken calls -> 5th still jumps to target, stack_full = 1, stack_err = 1.
  - 4 rets return the first 4 addresses in LIFO order.
  - 5th ret -> pc increments; stack_err stays 1 until rst.
- Stall and wrap, ADDR_W = 4:
  - pc = 0xF, en = 0 for 3 cycles -> pc holds 0xF, taken = 0 despite j = 111.
  - en = 1, c_instr = 0 -> pc = 0x0.
- Priority and reset mid-op:
  - ret = 1 and call = 1 with j = 111, stack holding 0x0042 -> pc = 0x0042, no push.
  - Push 2 entries, assert rst -> pc = 0, stack_empty = 1, stack_err = 0.
